// File: rtl/rx_frame_dma_pkg.sv
// Shared e1000 RX DMA definitions: AXI encodings, status word layout, FSM states
// and the residual-strobe helpers used by the burst buffer.
package rx_frame_dma_pkg;

   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   localparam int RXS_LEN   = 0;
   localparam int RXS_LEN_W = 16;
   localparam int RXS_EOP   = 16;
   localparam int RXS_BERR  = 17;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_AW,
      ST_W,
      ST_B,
      ST_STAT
   } rx_state_e;

   // Strobe for the final beat of a burst; res is the byte count mod 4.
   function automatic logic [3:0] tail_strb(input logic [1:0] res);
      case (res)
         2'd1:    return 4'b0001;
         2'd2:    return 4'b0011;
         2'd3:    return 4'b0111;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{strb[i]}};
      return m;
   endfunction

endpackage

// File: rtl/rx_burst_buf.sv
// One-burst staging buffer: packs bytes little-endian into 32-bit words and
// presents a read beat with its strobe, zeroing lanes beyond the burst tail.
module rx_burst_buf
   import rx_frame_dma_pkg::*;
#(
   parameter  int BURST_BEATS = 16,
   localparam int IW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1
) (
   input  logic          aclk,
   input  logic          wr_en_i,
   input  logic [IW+1:0] wr_pos_i,
   input  logic [7:0]    wr_byte_i,
   input  logic [IW-1:0] rd_idx_i,
   input  logic [IW-1:0] last_idx_i,
   input  logic [1:0]    res_i,
   output logic [31:0]   rd_data_o,
   output logic [3:0]    rd_strb_o
);

   logic [BURST_BEATS-1:0][31:0] mem_q;

   // Storage needs no reset: every lane read out is either written this burst or masked.
   always_ff @(posedge aclk) begin
      if (wr_en_i) mem_q[wr_pos_i[IW+1:2]][wr_pos_i[1:0]*8 +: 8] <= wr_byte_i;
   end

   always_comb begin
      rd_strb_o = (rd_idx_i == last_idx_i) ? tail_strb(res_i) : 4'hF;
      rd_data_o = mem_q[rd_idx_i] & strb_mask(rd_strb_o);
   end

endmodule

// File: rtl/rx_frame_dma.sv
// Receive DMA: collects MAC RX bytes one burst at a time, writes each burst to
// the host buffer as an aligned AXI3 INCR burst and returns one status per buffer.
module rx_frame_dma
   import rx_frame_dma_pkg::*;
#(
   parameter int BURST_BEATS = 16,
   parameter int BUF_BYTES   = 2048
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [63:0] cmd_s_tdata,
   input  logic        cmd_s_tvalid,
   output logic        cmd_s_tready,
   output logic [31:0] stat_m_tdata,
   output logic        stat_m_tvalid,
   input  logic        stat_m_tready,
   input  logic [7:0]  mac_s_tdata,
   input  logic        mac_s_tvalid,
   input  logic        mac_s_tlast,
   output logic        mac_s_tready,
   output logic [3:0]  axi_m_awid,
   output logic [63:0] axi_m_awaddr,
   output logic [7:0]  axi_m_awlen,
   output logic [2:0]  axi_m_awsize,
   output logic [1:0]  axi_m_awburst,
   output logic        axi_m_awvalid,
   input  logic        axi_m_awready,
   output logic [3:0]  axi_m_wid,
   output logic [31:0] axi_m_wdata,
   output logic [3:0]  axi_m_wstrb,
   output logic        axi_m_wlast,
   output logic        axi_m_wvalid,
   input  logic        axi_m_wready,
   input  logic [3:0]  axi_m_bid,
   input  logic [1:0]  axi_m_bresp,
   input  logic        axi_m_bvalid,
   output logic        axi_m_bready
);

   localparam int BURST_BYTES = BURST_BEATS * 4;
   localparam int IW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam int CW = $clog2(BURST_BYTES) + 1;
   localparam logic [63:0] ADDR_MASK = ~64'(BURST_BYTES - 1);

   rx_state_e     state_q;
   logic          cmd_rdy_q, mac_rdy_q, awvalid_q, wvalid_q, wlast_q, bready_q, stat_valid_q;
   logic [63:0]   base_q, awaddr_q;
   logic [7:0]    awlen_q;
   logic [31:0]   wdata_q, stat_q;
   logic [3:0]    wstrb_q;
   logic [15:0]   off_q, buf_cnt_q, buf_cnt_d;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;
   logic [IW-1:0] beat_q, rd_idx, last_idx;
   logic          eop_seen_q, err_q, err_d;
   logic          mac_hs, close_burst, buf_wr_en;
   logic [31:0]   rd_data, stat_d;
   logic [3:0]    rd_strb;
   logic          unused_bid;

   assign unused_bid = ^axi_m_bid;

   assign mac_hs      = mac_rdy_q & mac_s_tvalid;
   assign buf_cnt_d   = buf_cnt_q + 16'd1;
   assign burst_cnt_d = burst_cnt_q + 1'b1;
   assign close_burst = (burst_cnt_d == CW'(BURST_BYTES)) | mac_s_tlast |
                        (buf_cnt_d == 16'(BUF_BYTES));
   assign buf_wr_en   = (state_q == ST_FILL) & mac_hs;

   // During W the buffer is read one beat ahead so wdata can be registered.
   assign rd_idx   = (state_q == ST_W) ? beat_q + 1'b1 : '0;
   assign last_idx = awlen_q[IW-1:0];
   assign err_d    = err_q | (axi_m_bresp != AXI_RESP_OKAY);

   always_comb begin
      stat_d = '0;
      stat_d[RXS_LEN +: RXS_LEN_W] = buf_cnt_q;
      stat_d[RXS_EOP]              = eop_seen_q;
      stat_d[RXS_BERR]             = err_d;
   end

   rx_burst_buf #(.BURST_BEATS(BURST_BEATS)) u_buf (
      .aclk       (aclk),
      .wr_en_i    (buf_wr_en),
      .wr_pos_i   (burst_cnt_q[IW+1:0]),
      .wr_byte_i  (mac_s_tdata),
      .rd_idx_i   (rd_idx),
      .last_idx_i (last_idx),
      .res_i      (burst_cnt_q[1:0]),
      .rd_data_o  (rd_data),
      .rd_strb_o  (rd_strb)
   );

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= ST_IDLE;
         cmd_rdy_q    <= 1'b0;
         mac_rdy_q    <= 1'b0;
         awvalid_q    <= 1'b0;
         awaddr_q     <= '0;
         awlen_q      <= '0;
         wvalid_q     <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         wlast_q      <= 1'b0;
         bready_q     <= 1'b0;
         stat_valid_q <= 1'b0;
         stat_q       <= '0;
         base_q       <= '0;
         off_q        <= '0;
         buf_cnt_q    <= '0;
         burst_cnt_q  <= '0;
         beat_q       <= '0;
         eop_seen_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_rdy_q && cmd_s_tvalid) begin
                  base_q      <= cmd_s_tdata & ADDR_MASK;
                  off_q       <= '0;
                  buf_cnt_q   <= '0;
                  burst_cnt_q <= '0;
                  eop_seen_q  <= 1'b0;
                  err_q       <= 1'b0;
                  cmd_rdy_q   <= 1'b0;
                  mac_rdy_q   <= 1'b1;
                  state_q     <= ST_FILL;
               end else begin
                  cmd_rdy_q <= 1'b1;
               end
            end
            ST_FILL: begin
               if (mac_hs) begin
                  buf_cnt_q   <= buf_cnt_d;
                  burst_cnt_q <= burst_cnt_d;
                  if (mac_s_tlast) eop_seen_q <= 1'b1;
                  if (close_burst) begin
                     mac_rdy_q <= 1'b0;
                     awvalid_q <= 1'b1;
                     awaddr_q  <= base_q + 64'(off_q);
                     // ceil(n/4)-1 with n = burst_cnt_q+1
                     awlen_q   <= 8'(burst_cnt_q >> 2);
                     state_q   <= ST_AW;
                  end
               end
            end
            ST_AW: begin
               if (axi_m_awready) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b1;
                  wdata_q   <= rd_data;
                  wstrb_q   <= rd_strb;
                  wlast_q   <= (last_idx == '0);
                  beat_q    <= '0;
                  state_q   <= ST_W;
               end
            end
            ST_W: begin
               if (axi_m_wready) begin
                  if (wlast_q) begin
                     wvalid_q <= 1'b0;
                     wlast_q  <= 1'b0;
                     wdata_q  <= '0;
                     wstrb_q  <= '0;
                     bready_q <= 1'b1;
                     state_q  <= ST_B;
                  end else begin
                     beat_q  <= rd_idx;
                     wdata_q <= rd_data;
                     wstrb_q <= rd_strb;
                     wlast_q <= (rd_idx == last_idx);
                  end
               end
            end
            ST_B: begin
               if (axi_m_bvalid) begin
                  bready_q <= 1'b0;
                  err_q    <= err_d;
                  if (eop_seen_q || buf_cnt_q == 16'(BUF_BYTES)) begin
                     stat_q       <= stat_d;
                     stat_valid_q <= 1'b1;
                     state_q      <= ST_STAT;
                  end else begin
                     off_q       <= off_q + 16'(BURST_BYTES);
                     burst_cnt_q <= '0;
                     mac_rdy_q   <= 1'b1;
                     state_q     <= ST_FILL;
                  end
               end
            end
            ST_STAT: begin
               if (stat_m_tready) begin
                  stat_valid_q <= 1'b0;
                  cmd_rdy_q    <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_s_tready  = cmd_rdy_q;
   assign mac_s_tready  = mac_rdy_q;
   assign stat_m_tdata  = stat_q;
   assign stat_m_tvalid = stat_valid_q;
   assign axi_m_awid    = 4'd0;
   assign axi_m_awaddr  = awaddr_q;
   assign axi_m_awlen   = awlen_q;
   assign axi_m_awsize  = AXI_SIZE_4B;
   assign axi_m_awburst = AXI_BURST_INCR;
   assign axi_m_awvalid = awvalid_q;
   assign axi_m_wid     = 4'd0;
   assign axi_m_wdata   = wdata_q;
   assign axi_m_wstrb   = wstrb_q;
   assign axi_m_wlast   = wlast_q;
   assign axi_m_wvalid  = wvalid_q;
   assign axi_m_bready  = bready_q;

endmodule

// File: tb/tb_rx_frame_dma.sv
// Scoreboard bench for rx_frame_dma: a buffer model queues the expected AW, W and
// status traffic; monitors pop and compare as the DUT produces it.
module tb_rx_frame_dma;

   localparam int BB  = 16;
   localparam int BUF = 2048;

   logic        aclk, aresetn;
   logic [63:0] cmd_s_tdata;
   logic        cmd_s_tvalid, cmd_s_tready;
   logic [31:0] stat_m_tdata;
   logic        stat_m_tvalid, stat_m_tready;
   logic [7:0]  mac_s_tdata;
   logic        mac_s_tvalid, mac_s_tlast, mac_s_tready;
   logic [3:0]  axi_m_awid, axi_m_wid, axi_m_bid;
   logic [63:0] axi_m_awaddr;
   logic [7:0]  axi_m_awlen;
   logic [2:0]  axi_m_awsize;
   logic [1:0]  axi_m_awburst, axi_m_bresp;
   logic        axi_m_awvalid, axi_m_awready;
   logic [31:0] axi_m_wdata;
   logic [3:0]  axi_m_wstrb;
   logic        axi_m_wlast, axi_m_wvalid, axi_m_wready;
   logic        axi_m_bvalid, axi_m_bready;

   rx_frame_dma #(.BURST_BEATS(BB), .BUF_BYTES(BUF)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_s_tdata(cmd_s_tdata), .cmd_s_tvalid(cmd_s_tvalid), .cmd_s_tready(cmd_s_tready),
      .stat_m_tdata(stat_m_tdata), .stat_m_tvalid(stat_m_tvalid), .stat_m_tready(stat_m_tready),
      .mac_s_tdata(mac_s_tdata), .mac_s_tvalid(mac_s_tvalid), .mac_s_tlast(mac_s_tlast),
      .mac_s_tready(mac_s_tready),
      .axi_m_awid(axi_m_awid), .axi_m_awaddr(axi_m_awaddr), .axi_m_awlen(axi_m_awlen),
      .axi_m_awsize(axi_m_awsize), .axi_m_awburst(axi_m_awburst),
      .axi_m_awvalid(axi_m_awvalid), .axi_m_awready(axi_m_awready),
      .axi_m_wid(axi_m_wid), .axi_m_wdata(axi_m_wdata), .axi_m_wstrb(axi_m_wstrb),
      .axi_m_wlast(axi_m_wlast), .axi_m_wvalid(axi_m_wvalid), .axi_m_wready(axi_m_wready),
      .axi_m_bid(axi_m_bid), .axi_m_bresp(axi_m_bresp), .axi_m_bvalid(axi_m_bvalid),
      .axi_m_bready(axi_m_bready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [71:0] exp_aw[$];   // {awaddr, awlen}
   logic [36:0] exp_w[$];    // {wdata, wstrb, wlast}
   logic [31:0] exp_st[$];

   // slave / monitor configuration, written only by the test sequence
   int aw_delay = 0;
   bit w_toggle = 0;
   int stat_hold = 0;
   int err_at = -1;
   bit chk_mac = 0;
   bit mon_off = 0;

   // monitor-owned counters
   int aw_out = 0;
   int w_hs = 0;
   int b_req = 0;
   int b_hs = 0;

   // ---------------- AXI slave and status sink ----------------
   initial begin
      int cnt;
      cnt = 0;
      axi_m_awready = 1'b0;
      forever begin
         @(posedge aclk); #1;
         if (!axi_m_awvalid) begin
            axi_m_awready = 1'b0; cnt = 0;
         end else if (cnt < aw_delay) begin
            axi_m_awready = 1'b0; cnt++;
         end else axi_m_awready = 1'b1;
      end
   end

   initial begin
      axi_m_wready = 1'b1;
      forever begin
         @(posedge aclk); #1;
         axi_m_wready = w_toggle ? ~axi_m_wready : 1'b1;
      end
   end

   initial begin
      int issued, seen;
      issued = 0; seen = 0;
      axi_m_bvalid = 1'b0; axi_m_bresp = 2'b00; axi_m_bid = 4'd0;
      forever begin
         @(posedge aclk); #1;
         if (b_hs > seen) begin
            axi_m_bvalid = 1'b0; seen = b_hs;
         end
         if (!axi_m_bvalid && b_req > issued) begin
            issued++;
            axi_m_bvalid = 1'b1;
            axi_m_bresp  = (issued == err_at) ? 2'b10 : 2'b00;
         end
      end
   end

   initial begin
      int cnt;
      cnt = 0;
      stat_m_tready = 1'b0;
      forever begin
         @(posedge aclk); #1;
         if (!stat_m_tvalid) begin
            stat_m_tready = 1'b0; cnt = 0;
         end else if (cnt < stat_hold) begin
            stat_m_tready = 1'b0; cnt++;
         end else stat_m_tready = 1'b1;
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge aclk) begin
      logic [71:0] ea;
      logic [36:0] ew;
      logic [31:0] es;
      if (!aresetn) begin
         aw_out = 0;
      end else begin
         if (axi_m_wvalid && !mon_off) begin
            n_cmp++;
            if (aw_out == 0) begin
               $display("FAIL w_before_aw: wvalid with %0d open AW, need >=1", aw_out); n_bad++;
            end
         end
         if (chk_mac && (cmd_s_tready | axi_m_awvalid | axi_m_wvalid | axi_m_bready | stat_m_tvalid)) begin
            n_cmp++;
            if (mac_s_tready !== 1'b0) begin
               $display("FAIL mac_ready_outside_fill: got %b want 0", mac_s_tready); n_bad++;
            end
         end
         if (axi_m_awvalid && axi_m_awready) begin
            aw_out++;
            if (!mon_off) begin
               n_cmp++;
               if (exp_aw.size() == 0) begin
                  $display("FAIL aw_extra: got %h/%0d want none", axi_m_awaddr, axi_m_awlen); n_bad++;
               end else begin
                  ea = exp_aw.pop_front();
                  if ({axi_m_awaddr, axi_m_awlen} !== ea) begin
                     $display("FAIL aw: got %h/%0d want %h/%0d", axi_m_awaddr, axi_m_awlen,
                              ea[71:8], ea[7:0]); n_bad++;
                  end
               end
               n_cmp++;
               if ({axi_m_awid, axi_m_awsize, axi_m_awburst} !== {4'd0, 3'b010, 2'b01}) begin
                  $display("FAIL aw_const: got %h/%b/%b want 0/010/01", axi_m_awid, axi_m_awsize,
                           axi_m_awburst); n_bad++;
               end
            end
         end
         if (axi_m_wvalid && axi_m_wready) begin
            w_hs++;
            if (axi_m_wlast) begin b_req++; aw_out--; end
            if (!mon_off) begin
               n_cmp++;
               if (exp_w.size() == 0) begin
                  $display("FAIL w_extra: got %h/%h want none", axi_m_wdata, axi_m_wstrb); n_bad++;
               end else begin
                  ew = exp_w.pop_front();
                  if ({axi_m_wdata, axi_m_wstrb, axi_m_wlast} !== ew) begin
                     $display("FAIL w: got %h/%h/%b want %h/%h/%b", axi_m_wdata, axi_m_wstrb,
                              axi_m_wlast, ew[36:5], ew[4:1], ew[0]); n_bad++;
                  end
               end
            end
         end
         if (axi_m_bvalid && axi_m_bready) b_hs++;
         if (stat_m_tvalid && !stat_m_tready && stat_hold > 0 && exp_st.size() > 0) begin
            n_cmp++;
            if (stat_m_tdata !== exp_st[0]) begin
               $display("FAIL stat_hold: got %h want %h", stat_m_tdata, exp_st[0]); n_bad++;
            end
         end
         if (stat_m_tvalid && stat_m_tready && !mon_off) begin
            n_cmp++;
            if (exp_st.size() == 0) begin
               $display("FAIL stat_extra: got %h want none", stat_m_tdata); n_bad++;
            end else begin
               es = exp_st.pop_front();
               if (stat_m_tdata !== es) begin
                  $display("FAIL stat: got %h want %h", stat_m_tdata, es); n_bad++;
               end
            end
         end
      end
   end

   // ---------------- model and drivers ----------------
   // Expected traffic for one buffer; frame byte k carries value seed+k.
   task automatic model_buf(input logic [63:0] cmd, input int flen, input int done,
                            input int seed, input bit err);
      logic [63:0] base;
      int n, bb, nb;
      logic [31:0] d;
      logic [3:0] s;
      base = cmd & ~64'd63;
      n = flen - done;
      if (n > BUF) n = BUF;
      for (int off = 0; off < n; off += 64) begin
         bb = (n - off < 64) ? n - off : 64;
         nb = (bb + 3) / 4;
         exp_aw.push_back({base + 64'(off), 8'(nb - 1)});
         for (int b = 0; b < nb; b++) begin
            d = '0; s = '0;
            for (int l = 0; l < 4; l++) begin
               if (b*4 + l < bb) begin
                  d[l*8 +: 8] = 8'(seed + done + off + b*4 + l);
                  s[l] = 1'b1;
               end
            end
            exp_w.push_back({d, s, (b == nb - 1)});
         end
      end
      exp_st.push_back({14'd0, err, (done + n == flen), 16'(n)});
   endtask

   task automatic send_cmd(input logic [63:0] addr);
      int c;
      c = 0;
      cmd_s_tdata = addr; cmd_s_tvalid = 1'b1;
      @(negedge aclk);
      while (!cmd_s_tready && c < 20000) begin @(negedge aclk); c++; end
      if (c >= 20000) begin
         n_cmp++; n_bad++;
         $display("FAIL cmd_timeout: cmd_s_tready stayed %b, want 1", cmd_s_tready);
      end
      @(posedge aclk); #1;
      cmd_s_tvalid = 1'b0;
   endtask

   task automatic send_frame(input int len, input int seed);
      int c;
      for (int k = 0; k < len; k++) begin
         mac_s_tdata = 8'(seed + k); mac_s_tvalid = 1'b1; mac_s_tlast = (k == len - 1);
         c = 0;
         @(negedge aclk);
         while (!mac_s_tready && c < 5000) begin @(negedge aclk); c++; end
         if (c >= 5000) begin
            n_cmp++; n_bad++;
            $display("FAIL mac_timeout: byte %0d mac_s_tready %b want 1", k, mac_s_tready);
            break;
         end
         @(posedge aclk); #1;
      end
      mac_s_tvalid = 1'b0; mac_s_tlast = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int c;
      c = 0;
      while ((exp_aw.size() + exp_w.size() + exp_st.size()) != 0 && c < limit) begin
         @(negedge aclk); c++;
      end
      @(posedge aclk); #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      n_cmp++;
      if ({cmd_s_tready, mac_s_tready, axi_m_awvalid, axi_m_wvalid, axi_m_bready, stat_m_tvalid} !== 6'b0) begin
         $display("FAIL reset_valids: got %b want 000000", {cmd_s_tready, mac_s_tready,
                  axi_m_awvalid, axi_m_wvalid, axi_m_bready, stat_m_tvalid}); n_bad++;
      end
      n_cmp++;
      if ({axi_m_awaddr, axi_m_awlen, axi_m_wdata, axi_m_wstrb, axi_m_wlast} !== 109'd0) begin
         $display("FAIL reset_data: awaddr %h awlen %h wdata %h wstrb %h wlast %b want all 0",
                  axi_m_awaddr, axi_m_awlen, axi_m_wdata, axi_m_wstrb, axi_m_wlast); n_bad++;
      end
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(posedge aclk); #1;
   endtask

   task automatic run_frame(input string nm, input logic [63:0] cmd, input int len, input int seed);
      model_buf(cmd, len, 0, seed, 1'b0);
      fork
         send_cmd(cmd);
         send_frame(len, seed);
      join
      wait_idle(5000);
      n_cmp++;
      if (exp_aw.size() + exp_w.size() + exp_st.size() != 0) begin
         $display("FAIL %s_drain: %0d entries left, want 0", nm,
                  exp_aw.size() + exp_w.size() + exp_st.size()); n_bad++;
      end
      exp_aw.delete(); exp_w.delete(); exp_st.delete();
   endtask

   task automatic test_short_frame();
      run_frame("short60", 64'h1000, 60, 0);
   endtask

   task automatic test_residual();
      run_frame("res65", 64'h1000, 65, 0);
   endtask

   task automatic test_exact_buffer();
      run_frame("exact", 64'h4000, BUF, 7);
   endtask

   task automatic test_multi_buffer();
      model_buf(64'h2000, 3000, 0, 0, 1'b0);
      model_buf(64'h8000, 3000, BUF, 0, 1'b0);
      fork
         begin send_cmd(64'h2000); send_cmd(64'h8000); end
         send_frame(3000, 0);
      join
      wait_idle(8000);
      n_cmp++;
      if (exp_aw.size() + exp_w.size() + exp_st.size() != 0) begin
         $display("FAIL multi_drain: %0d entries left, want 0",
                  exp_aw.size() + exp_w.size() + exp_st.size()); n_bad++;
      end
      exp_aw.delete(); exp_w.delete(); exp_st.delete();
   endtask

   task automatic test_bus_error();
      err_at = b_hs + 2;
      model_buf(64'h5000, 128, 0, 9, 1'b1);
      fork
         send_cmd(64'h5000);
         send_frame(128, 9);
      join
      wait_idle(5000);
      n_cmp++;
      if (exp_aw.size() + exp_w.size() + exp_st.size() != 0) begin
         $display("FAIL berr_drain: %0d entries left, want 0",
                  exp_aw.size() + exp_w.size() + exp_st.size()); n_bad++;
      end
      exp_aw.delete(); exp_w.delete(); exp_st.delete();
      err_at = -1;
   endtask

   task automatic test_backpressure();
      aw_delay = 5; w_toggle = 1; stat_hold = 10; chk_mac = 1;
      run_frame("bp", 64'h3025, 100, 8'h55);
      aw_delay = 0; w_toggle = 0; stat_hold = 0; chk_mac = 0;
      repeat (2) @(posedge aclk); #1;
   endtask

   task automatic test_reset_mid_burst();
      int c, w0;
      mon_off = 1;
      w0 = w_hs;
      fork
         send_cmd(64'h1000);
         send_frame(60, 0);
      join
      c = 0;
      while (w_hs < w0 + 3 && c < 500) begin @(negedge aclk); c++; end
      n_cmp++;
      if (w_hs < w0 + 3) begin
         $display("FAIL midw_reach: %0d beats seen, want 3", w_hs - w0); n_bad++;
      end
      @(posedge aclk); #1;
      aresetn = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk);
      n_cmp++;
      if ({cmd_s_tready, mac_s_tready, axi_m_awvalid, axi_m_wvalid, axi_m_bready, stat_m_tvalid} !== 6'b0) begin
         $display("FAIL midw_valids: got %b want 000000", {cmd_s_tready, mac_s_tready,
                  axi_m_awvalid, axi_m_wvalid, axi_m_bready, stat_m_tvalid}); n_bad++;
      end
      @(posedge aclk); #1;
      mon_off = 0;
      run_frame("after_rst", 64'h1000, 60, 0);
   endtask

   initial begin
      aresetn = 1'b0;
      cmd_s_tdata = '0; cmd_s_tvalid = 1'b0;
      mac_s_tdata = '0; mac_s_tvalid = 1'b0; mac_s_tlast = 1'b0;
      test_reset();
      test_short_frame();
      test_residual();
      test_multi_buffer();
      test_exact_buffer();
      test_bus_error();
      test_backpressure();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
